// File: rtl/pll_drp_sequencer.sv
// Purpose : holds a PLLE2_ADV in reset, applies a table of DRP read-modify-write
//           updates (addr, keep-mask, data), releases reset and waits for LOCKED.
// Latency : RST_CYCLES + per entry (2 DRP accesses + drdy latency) + lock time.
// Backpr. : one DRP access outstanding at a time; den waits for drdy or timeout.
//
// Ports:
//   clk_i / rst_i            single clock (also PLL DCLK), synchronous active-high reset
//   cfg_we_i/waddr_i/wdata_i table write port, ignored while busy
//                            wdata = {addr[38:32], keep_mask[31:16], data[15:0]}
//   cfg_count_i, start_i     number of entries to apply, start request (IDLE only)
//   busy_o, done_o           sequence in flight / one-cycle completion pulse
//   error_o, err_code_o      sticky error, 1 drdy timeout, 2 lock timeout, 3 readback
//   pll_rst_o, daddr_o, den_o, dwe_o, di_o, do_in_i, drdy_i, locked_i   PLL side
//
// Optional feature: define PLL_DRP_READBACK_EN to re-read every written register
// and compare it against the value just written.
module pll_drp_sequencer #(
    parameter int ENTRY_BITS   = 4,
    parameter int RST_CYCLES   = 16,
    parameter int DRDY_TIMEOUT = 64,
    parameter int LOCK_TIMEOUT = 65536
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cfg_we_i,
    input  logic [ENTRY_BITS-1:0] cfg_waddr_i,
    input  logic [38:0]           cfg_wdata_i,
    input  logic [ENTRY_BITS:0]   cfg_count_i,
    input  logic                  start_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  error_o,
    output logic [1:0]            err_code_o,
    output logic                  pll_rst_o,
    output logic [6:0]            daddr_o,
    output logic                  den_o,
    output logic                  dwe_o,
    output logic [15:0]           di_o,
    input  logic [15:0]           do_in_i,
    input  logic                  drdy_i,
    input  logic                  locked_i
);

    localparam int TMAX0 = (RST_CYCLES > DRDY_TIMEOUT) ? RST_CYCLES : DRDY_TIMEOUT;
    localparam int TMAX  = (TMAX0 > LOCK_TIMEOUT) ? TMAX0 : LOCK_TIMEOUT;
    localparam int TW    = $clog2(TMAX + 1);

    // Terminal timer values: a state lasts exactly N cycles before it gives up.
    localparam logic [TW-1:0] RST_LAST  = TW'(RST_CYCLES - 1);
    localparam logic [TW-1:0] DRDY_LAST = TW'(DRDY_TIMEOUT - 1);
    localparam logic [TW-1:0] LOCK_LAST = TW'(LOCK_TIMEOUT - 1);
    localparam logic [TW-1:0] TMR_ONE   = TW'(1);
    localparam logic [ENTRY_BITS:0] IDX_ONE = (ENTRY_BITS + 1)'(1);

    typedef enum logic [3:0] {
        S_IDLE, S_RST_HOLD, S_RD_REQ, S_RD_WAIT, S_WR_REQ, S_WR_WAIT,
        S_NEXT, S_RELEASE, S_LOCK_WAIT, S_ERROR, S_VF_REQ, S_VF_WAIT
    } state_t;

    state_t              state_q, state_d;
    logic [TW-1:0]       timer_q, timer_d;
    logic [ENTRY_BITS:0] idx_q, idx_d;
    logic [ENTRY_BITS:0] count_q, count_d;
    logic [15:0]         wr_val_q, wr_val_d;
    logic                pll_rst_q, pll_rst_d;
    logic                done_q, done_d;
    logic                error_q, error_d;
    logic [1:0]          err_code_q, err_code_d;
    logic                lock_s1_q, lock_s2_q;
    logic                busy_w;

    logic [38:0] tbl_q [2**ENTRY_BITS];
    logic [38:0] ent;
    logic [6:0]  ent_addr;
    logic [15:0] ent_mask, ent_data;
    logic [ENTRY_BITS:0] idx_inc;

    assign ent      = tbl_q[idx_q[ENTRY_BITS-1:0]];
    assign ent_addr = ent[38:32];
    assign ent_mask = ent[31:16];
    assign ent_data = ent[15:0];
    assign idx_inc  = idx_q + IDX_ONE;

    // Table contents carry no reset; the host rewrites them before use.
    always_ff @(posedge clk_i) begin
        if (cfg_we_i && !busy_w) begin
            tbl_q[cfg_waddr_i] <= cfg_wdata_i;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            timer_q    <= '0;
            idx_q      <= '0;
            count_q    <= '0;
            wr_val_q   <= '0;
            pll_rst_q  <= 1'b1;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            err_code_q <= 2'd0;
            lock_s1_q  <= 1'b0;
            lock_s2_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            idx_q      <= idx_d;
            count_q    <= count_d;
            wr_val_q   <= wr_val_d;
            pll_rst_q  <= pll_rst_d;
            done_q     <= done_d;
            error_q    <= error_d;
            err_code_q <= err_code_d;
            lock_s1_q  <= locked_i;
            lock_s2_q  <= lock_s1_q;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        count_d    = count_q;
        wr_val_d   = wr_val_q;
        done_d     = 1'b0;
        error_d    = error_q;
        err_code_d = err_code_q;
        timer_d    = '0;
        pll_rst_d  = pll_rst_q;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    count_d    = cfg_count_i;
                    error_d    = 1'b0;
                    err_code_d = 2'd0;
                    idx_d      = '0;
                    state_d    = S_RST_HOLD;
                end
            end
            S_RST_HOLD: begin
                if (timer_q == RST_LAST) begin
                    state_d = (count_q != '0) ? S_RD_REQ : S_RELEASE;
                end
            end
            S_RD_REQ: state_d = S_RD_WAIT;
            S_RD_WAIT: begin
                // drdy wins over a simultaneous timer expiry.
                if (drdy_i) begin
                    wr_val_d = (do_in_i & ent_mask) | (ent_data & ~ent_mask);
                    state_d  = S_WR_REQ;
                end else if (timer_q == DRDY_LAST) begin
                    err_code_d = 2'd1;
                    state_d    = S_ERROR;
                end
            end
            S_WR_REQ: state_d = S_WR_WAIT;
            S_WR_WAIT: begin
                if (drdy_i) begin
`ifdef PLL_DRP_READBACK_EN
                    state_d = S_VF_REQ;
`else
                    state_d = S_NEXT;
`endif
                end else if (timer_q == DRDY_LAST) begin
                    err_code_d = 2'd1;
                    state_d    = S_ERROR;
                end
            end
`ifdef PLL_DRP_READBACK_EN
            S_VF_REQ: state_d = S_VF_WAIT;
            S_VF_WAIT: begin
                if (drdy_i) begin
                    if (do_in_i != wr_val_q) begin
                        err_code_d = 2'd3;
                        state_d    = S_ERROR;
                    end else begin
                        state_d = S_NEXT;
                    end
                end else if (timer_q == DRDY_LAST) begin
                    err_code_d = 2'd1;
                    state_d    = S_ERROR;
                end
            end
`endif
            S_NEXT: begin
                idx_d   = idx_inc;
                state_d = (idx_inc < count_q) ? S_RD_REQ : S_RELEASE;
            end
            S_RELEASE: state_d = S_LOCK_WAIT;
            S_LOCK_WAIT: begin
                if (lock_s2_q) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else if (timer_q == LOCK_LAST) begin
                    err_code_d = 2'd2;
                    state_d    = S_ERROR;
                end
            end
            S_ERROR: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (state_d == S_ERROR) begin
            error_d = 1'b1;
        end

        // Timer restarts on every state change; idle holds it at zero.
        if (state_d == state_q && state_q != S_IDLE) begin
            timer_d = timer_q + TMR_ONE;
        end

        // PLL reset is a register so it is glitch-free at the PLL pin. It drops
        // only for release/lock, and IDLE keeps whatever the last sequence left.
        if (state_d == S_RELEASE || state_d == S_LOCK_WAIT) begin
            pll_rst_d = 1'b0;
        end else if (state_d != S_IDLE) begin
            pll_rst_d = 1'b1;
        end
    end

    // Output decode.
    always_comb begin
        busy_w  = 1'b1;
        den_o   = 1'b0;
        dwe_o   = 1'b0;
        daddr_o = 7'd0;
        di_o    = 16'd0;
        case (state_q)
            S_IDLE, S_ERROR: busy_w = 1'b0;
            S_RD_REQ, S_VF_REQ: begin
                den_o   = 1'b1;
                daddr_o = ent_addr;
            end
            S_WR_REQ: begin
                den_o   = 1'b1;
                dwe_o   = 1'b1;
                daddr_o = ent_addr;
                di_o    = wr_val_q;
            end
            S_RD_WAIT, S_WR_WAIT, S_VF_WAIT: daddr_o = ent_addr;
            default: ;
        endcase
    end

    assign busy_o     = busy_w;
    assign done_o     = done_q;
    assign error_o    = error_q;
    assign err_code_o = err_code_q;
    assign pll_rst_o  = pll_rst_q;

endmodule

// File: doc/pll_drp_sequencer.md
Name: pll_drp_sequencer

Overview:
- Sequences dynamic reconfiguration of a PLLE2_ADV primitive through its DRP port.
- Holds the PLL in reset, then applies a small table of read-modify-write register updates (address, keep-mask, data).
- Releases reset and waits for LOCKED with a timeout.
- Sits between the host/configuration logic and the PLL that generates the DDR3 clock set; owns the PLL's RST, DADDR, DEN, DWE and DI pins.

Parameters:
- ENTRY_BITS, 4: log2 of table depth; table holds 2^ENTRY_BITS entries.
- RST_CYCLES, 16: clk cycles pll_rst is held asserted before the first DRP access.
- DRDY_TIMEOUT, 64: clk cycles to wait for drdy after each den pulse before flagging error.
- LOCK_TIMEOUT, 65536: clk cycles to wait for locked after pll_rst is released.

Ports:
- clk  in  1  Single clock; also drives the PLL DCLK.
- rst  in  1  Synchronous, active-high reset.
- cfg_we  in  1  Table write strobe (ignored while busy).
- cfg_waddr  in  ENTRY_BITS  Table entry index.
- cfg_wdata  in  39  Entry: [38:32] DRP address, [31:16] keep-mask (1 = keep old bit), [15:0] new data.
- cfg_count  in  ENTRY_BITS+1  Number of entries to apply, 0..2^ENTRY_BITS; sampled at start.
- start  in  1  Single-cycle request; accepted only in IDLE.
- busy  out  1  High from the cycle after start is accepted until DONE/ERROR is entered.
- done  out  1  One-cycle pulse on successful completion.
- error  out  1  Sticky error flag; cleared by the next accepted start or by rst.
- err_code  out  2  0 none, 1 drdy timeout, 2 lock timeout, 3 readback mismatch.
- pll_rst  out  1  To PLL RST.
- daddr  out  7  To PLL DADDR.
- den  out  1  To PLL DEN.
- dwe  out  1  To PLL DWE.
- di  out  16  To PLL DI.
- do_in  in  16  From PLL DO.
- drdy  in  1  From PLL DRDY.
- locked  in  1  From PLL LOCKED (asynchronous); double-flop synchronized internally.

Behaviour:
- Reset values: busy=0, done=0, error=0, err_code=0, pll_rst=1, den=0, dwe=0, daddr=0, di=0. FSM=IDLE, indices and counters zero.
- The PLL stays in reset after rst until the first successful sequence, unless cfg_count=0 is started (release only).
- Table: 2^ENTRY_BITS x 39 registers, written on cfg_we when not busy. No reset of contents.
- FSM states:
  - IDLE: on start, latch cfg_count, clear error/err_code, set idx=0, go to RST_HOLD.
  - RST_HOLD: pll_rst=1; count RST_CYCLES cycles. Then go to RD_REQ if count>0, else RELEASE.
  - RD_REQ: one-cycle den=1, dwe=0, daddr=entry[idx].addr; go to RD_WAIT.
  - RD_WAIT: on drdy, capture new = (do_in & mask) | (data & ~mask); go to WR_REQ.
  - WR_REQ: one-cycle den=1, dwe=1, di=new; go to WR_WAIT.
  - WR_WAIT: on drdy go to NEXT (or VERIFY_REQ with the optional feature).
  - NEXT: idx+1; go to RD_REQ if idx+1<count, else RELEASE.
  - RELEASE: pll_rst=0; clear the timer; go to LOCK_WAIT.
  - LOCK_WAIT: when synchronized locked=1, pulse done and go to IDLE.
  - ERROR: pll_rst=1, error=1; go to IDLE in the next cycle.
- den is never asserted while a DRP access is outstanding; exactly one den per access.
- Timeouts:
  - In every *_WAIT DRP state, a timer runs. If it reaches DRDY_TIMEOUT without drdy, set err_code=1 and go to ERROR.
  - In LOCK_WAIT, if LOCK_TIMEOUT elapses without locked, set err_code=2 and go to ERROR.
- Spurious drdy outside a wait state is ignored.
- drdy in the same cycle as the timer expiry counts as success.
- start while busy is ignored. rst mid-sequence aborts immediately to reset values (pll_rst=1).
- Loss of locked after done is not monitored.

Optional Feature:
- PLL_DRP_READBACK_EN defined:
  - After WR_WAIT, go to VERIFY_REQ (den=1, dwe=0, same address), then VERIFY_WAIT.
  - On drdy, compare do_in to the written value. On mismatch, set err_code=3 and go to ERROR; otherwise go to NEXT.
  - Adds 2 + drdy latency cycles per entry.
- Undefined: no verify states; err_code 3 is never produced.

Test Plan:
- Program entry0 = {addr 0x08, mask 0xF000, data 0x0145}, cfg_count=1, start; model returns do_in=0xA3FF → expect:
  - pll_rst=1 for 16 cycles;
  - read at 0x08, then write di=0xA145 at 0x08;
  - pll_rst falls, locked rises 100 cycles later, done pulses once, busy low.
- Three entries (0x08, 0x09, 0x14), drdy latency 3 → three read/write pairs in index order, never two den pulses outstanding, done after lock.
- DRP model never answers the read → error=1, err_code=1 after 64 cycles, pll_rst=1, busy=0. A new start clears error.
- locked held low → err_code=2 after 65536 cycles in LOCK_WAIT, pll_rst returns to 1.
- Assert rst during WR_WAIT → next cycle all outputs at reset values, FSM IDLE; start pulses during a busy sequence are ignored.
- With PLL_DRP_READBACK_EN, the model corrupts readback bit 0 → err_code=3. Without the macro, the same run completes with done.
